pipeline_run_monitor: RTL and testbench
=======================================

Name: pipeline_run_monitor

Overview:
Synthesizable run controller and monitor that sits between the board/bench clock-reset source and the pipelined MIPS core top level. It sequences the core's reset release and counts executed cycles. It detects program completion as the PC parked in a self-loop, enforces a watchdog timeout, and folds N probe buses (WriteData, HiOUT, LoOUT, ...) into a rolling signature for pass/fail comparison.

Parameters:
DATA_WIDTH, 32, width of PC and of each probe bus
NUM_PROBES, 3, number of probe channels packed into Probes
RST_CYCLES, 4, cycles CoreRst is held after reset release or Restart (>=1)
HALT_REPEAT, 8, consecutive equal-PC samples that declare halt (>=2)
TIMEOUT, 1048576, RUN cycles before watchdog fires
CNT_WIDTH, 32, CycleCount width

Ports:
Clk  in  1  single clock, rising edge
Rst  in  1  asynchronous, active-low reset
Restart  in  1  synchronous one-cycle pulse; re-runs the reset sequence
PCValue  in  DATA_WIDTH  core PC
Probes  in  NUM_PROBES*DATA_WIDTH  probe buses; channel k is bits [k*DATA_WIDTH +: DATA_WIDTH]
CoreRst  out  1  active-high reset to the core
Running  out  1  high in RUN
Done  out  1  high in HALTED or TIMEOUT (sticky)
TimedOut  out  1  high in TIMEOUT (sticky)
CycleCount  out  CNT_WIDTH  RUN cycles elapsed, saturating
HaltPC  out  DATA_WIDTH  PC captured at halt
Signature  out  DATA_WIDTH  rolling probe signature

Behaviour:
- All outputs registered. Rst low, asynchronously: state=HOLD, CoreRst=1, Running=0, Done=0, TimedOut=0, CycleCount=0, HaltPC=0, Signature=0, hold count=0, stable count=0, prev-PC valid=0.
- States: HOLD, RUN, HALTED, TIMEOUT.
- HOLD:
  - hold count increments each edge.
  - On the edge where hold count == RST_CYCLES-1: go to RUN, CoreRst<=0, Running<=1.
  - CoreRst is high for exactly RST_CYCLES rising edges after Rst deasserts.
- RUN, each edge:
  - CycleCount+1, saturating at all-ones.
  - prev PC<=PCValue; prev-PC valid<=1.
  - If valid and PCValue==prev PC, stable+1; else stable<=0.
  - Signature <= rotl1(Signature) XOR Probes[ch0] XOR ... XOR Probes[chN-1].
- Halt: in RUN, when stable==HALT_REPEAT-2 and PCValue==prev PC (HALT_REPEAT equal consecutive samples):
  - go to HALTED, Done<=1, Running<=0, HaltPC<=PCValue.
  - The cycle and signature updates of that edge still apply.
- Timeout: in RUN, when CycleCount==TIMEOUT-1 and the halt condition is false:
  - go to TIMEOUT, Done<=1, TimedOut<=1, Running<=0.
  - HaltPC<=PCValue.
- Halt and timeout on the same edge: halt wins, TimedOut stays 0.
- HALTED/TIMEOUT: sticky. CycleCount, Signature and HaltPC are frozen. CoreRst stays 0, so the core keeps running unobserved.
- Restart=1 in any state: next edge behaves exactly as the reset values above, except reset is synchronous. Restart in HOLD restarts the hold count. Restart has priority over halt and timeout on the same edge.
- Rst low at any time, including mid-RUN, aborts immediately (async). Restart is ignored while Rst is low.
- The PC comparison is full DATA_WIDTH equality, with no masking.

Optional Feature:
Macro RUN_MONITOR_SIG_EN.
- Defined: Signature logic as described.
- Undefined: no signature register is built, Signature is tied to 0, and probe inputs are unused. All other behaviour is unchanged.

Test Plan:
1. Reset sequence: Rst low 3 cycles, then high, default params → CoreRst high for exactly 4 edges after release, then Running=1, CycleCount=0 on the first RUN cycle.
2. Halt: PC steps 0,4,8,12 then stays 12 → Done=1 and HaltPC=12 on the edge of the 8th consecutive 12 sample. Running=0, TimedOut=0, CycleCount frozen.
3. Timeout, TIMEOUT=16: PC increments by 4 each cycle → TimedOut=1 and Done=1 after 16 RUN cycles. CycleCount=16, HaltPC equals the PC sampled at that edge.
4. Signature (macro defined), NUM_PROBES=3: probes constant 0x1, 0x2, 0x4 for 3 RUN cycles from Signature=0 → 0x7, then 0x9, then 0x15. Macro undefined → Signature stays 0.
5. Collision, TIMEOUT=HALT_REPEAT=8: PC constant from the first RUN cycle → halt and timeout coincide, Done=1, TimedOut=0.
6. Abort and restart: Restart pulse mid-RUN → CoreRst reasserts for 4 edges and all counters and Signature clear. Rst low mid-HOLD → immediate return to reset values.

Source files
------------

// File: rtl/pipeline_run_monitor.sv
// pipeline_run_monitor
//
// Run controller and monitor placed between the clock/reset source and the
// pipelined MIPS core top level. It holds the core in reset for RST_CYCLES
// edges, then counts RUN cycles. It declares completion when the PC has parked
// in a self-loop for HALT_REPEAT consecutive samples, or when a watchdog of
// TIMEOUT RUN cycles expires. Optionally it folds the probe buses into a
// rolling signature.
//
// Optional feature macro: RUN_MONITOR_SIG_EN
//   defined   -> Signature = rotl1(Signature) ^ probe[0] ^ ... ^ probe[N-1]
//                on every RUN edge
//   undefined -> no signature register, Signature tied to 0, Probes unused
//
// Ports
//   Clk        in   rising-edge clock
//   Rst        in   asynchronous active-low reset
//   Restart    in   synchronous one-cycle pulse, re-runs the reset sequence
//   PCValue    in   core PC (DATA_WIDTH)
//   Probes     in   NUM_PROBES probe buses, channel k = [k*DATA_WIDTH +: DATA_WIDTH]
//   CoreRst    out  active-high reset to the core
//   Running    out  high in RUN
//   Done       out  high in HALTED or TIMEOUT (sticky)
//   TimedOut   out  high in TIMEOUT (sticky)
//   CycleCount out  RUN cycles elapsed, saturating (CNT_WIDTH)
//   HaltPC     out  PC captured on the completing edge
//   Signature  out  rolling probe signature
//
// The FSM state is fully observable on the outputs:
//   HOLD = CoreRst, RUN = Running, HALTED = Done & !TimedOut, TIMEOUT = TimedOut.
module pipeline_run_monitor #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_PROBES  = 3,
    parameter int RST_CYCLES  = 4,
    parameter int HALT_REPEAT = 8,
    parameter int TIMEOUT     = 1048576,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic                             Restart,
    input  logic [DATA_WIDTH-1:0]            PCValue,
    input  logic [NUM_PROBES*DATA_WIDTH-1:0] Probes,
    output logic                             CoreRst,
    output logic                             Running,
    output logic                             Done,
    output logic                             TimedOut,
    output logic [CNT_WIDTH-1:0]             CycleCount,
    output logic [DATA_WIDTH-1:0]            HaltPC,
    output logic [DATA_WIDTH-1:0]            Signature
);

    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int STB_W  = $clog2(HALT_REPEAT);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RUN     = 2'd1,
        S_HALTED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [STB_W-1:0]        stable_q, stable_d;
    logic [DATA_WIDTH-1:0]   prev_pc_q, prev_pc_d;
    logic                    prev_valid_q, prev_valid_d;
    logic                    core_rst_q, core_rst_d;
    logic                    running_q, running_d;
    logic                    done_q, done_d;
    logic                    timed_out_q, timed_out_d;
    logic [CNT_WIDTH-1:0]    cycle_q, cycle_d;
    logic [DATA_WIDTH-1:0]   halt_pc_q, halt_pc_d;

    logic hold_last;
    logic pc_eq;
    logic halt_hit;
    logic timeout_hit;

    assign hold_last = (hold_cnt_q == HOLD_W'(RST_CYCLES - 1));
    // Only a sample with a valid predecessor can count as a repeat, so the
    // reset value of prev_pc_q never contributes to a halt.
    assign pc_eq     = prev_valid_q && (PCValue == prev_pc_q);
    // stable_q counts repeats already seen; this sample is repeat number
    // HALT_REPEAT-1, i.e. the HALT_REPEAT-th equal sample.
    assign halt_hit    = pc_eq && (stable_q == STB_W'(HALT_REPEAT - 2));
    assign timeout_hit = (cycle_q == CNT_WIDTH'(TIMEOUT - 1)) && !halt_hit;

    // ---------------- state register ----------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HOLD:    if (hold_last) state_d = S_RUN;
            S_RUN: begin
                if (halt_hit)         state_d = S_HALTED;
                else if (timeout_hit) state_d = S_TIMEOUT;
            end
            S_HALTED:  state_d = S_HALTED;
            S_TIMEOUT: state_d = S_TIMEOUT;
            default:   state_d = S_HOLD;
        endcase
        if (Restart) state_d = S_HOLD;
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        stable_d     = stable_q;
        prev_pc_d    = prev_pc_q;
        prev_valid_d = prev_valid_q;
        core_rst_d   = core_rst_q;
        running_d    = running_q;
        done_d       = done_q;
        timed_out_d  = timed_out_q;
        cycle_d      = cycle_q;
        halt_pc_d    = halt_pc_q;

        if (Restart) begin
            hold_cnt_d   = '0;
            stable_d     = '0;
            prev_pc_d    = '0;
            prev_valid_d = 1'b0;
            core_rst_d   = 1'b1;
            running_d    = 1'b0;
            done_d       = 1'b0;
            timed_out_d  = 1'b0;
            cycle_d      = '0;
            halt_pc_d    = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    if (hold_last) begin
                        core_rst_d = 1'b0;
                        running_d  = 1'b1;
                    end
                end
                S_RUN: begin
                    if (cycle_q != {CNT_WIDTH{1'b1}}) cycle_d = cycle_q + 1'b1;
                    prev_pc_d    = PCValue;
                    prev_valid_d = 1'b1;
                    stable_d     = pc_eq ? stable_q + 1'b1 : '0;
                    if (halt_hit) begin
                        done_d    = 1'b1;
                        running_d = 1'b0;
                        halt_pc_d = PCValue;
                    end else if (timeout_hit) begin
                        done_d      = 1'b1;
                        timed_out_d = 1'b1;
                        running_d   = 1'b0;
                        halt_pc_d   = PCValue;
                    end
                end
                default: ; // HALTED / TIMEOUT: everything frozen
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hold_cnt_q   <= '0;
            stable_q     <= '0;
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            core_rst_q   <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            cycle_q      <= '0;
            halt_pc_q    <= '0;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            stable_q     <= stable_d;
            prev_pc_q    <= prev_pc_d;
            prev_valid_q <= prev_valid_d;
            core_rst_q   <= core_rst_d;
            running_q    <= running_d;
            done_q       <= done_d;
            timed_out_q  <= timed_out_d;
            cycle_q      <= cycle_d;
            halt_pc_q    <= halt_pc_d;
        end
    end

    assign CoreRst    = core_rst_q;
    assign Running    = running_q;
    assign Done       = done_q;
    assign TimedOut   = timed_out_q;
    assign CycleCount = cycle_q;
    assign HaltPC     = halt_pc_q;

    // ---------------- optional rolling signature ----------------
`ifdef RUN_MONITOR_SIG_EN
    logic [DATA_WIDTH-1:0] sig_q, sig_d;
    logic [DATA_WIDTH-1:0] probe_fold;

    always_comb begin
        probe_fold = '0;
        for (int k = 0; k < NUM_PROBES; k++) begin
            probe_fold = probe_fold ^ Probes[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        sig_d = sig_q;
        if (Restart) begin
            sig_d = '0;
        end else if (state_q == S_RUN) begin
            sig_d = {sig_q[DATA_WIDTH-2:0], sig_q[DATA_WIDTH-1]} ^ probe_fold;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign Signature = sig_q;
`else
    logic unused_probes;
    assign unused_probes = ^Probes;
    assign Signature     = '0;
`endif

endmodule

// File: tb/tb_pipeline_run_monitor.sv
// Bench for pipeline_run_monitor. Two instances share all inputs:
//   dut_a : default parameters except TIMEOUT=16
//   dut_c : TIMEOUT=8 (= HALT_REPEAT), for the halt/timeout collision
// Completion events (Done rising) are checked against expected queues by
// per-instance monitors; cycle-level behaviour is checked directly by the driver.
module tb_pipeline_run_monitor;

  localparam int DW = 32;
  localparam int NP = 3;
  localparam int EW = 1 + 3 * DW;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Restart;
  logic [DW-1:0] PCValue;
  logic [NP*DW-1:0] Probes;

  logic          a_CoreRst, a_Running, a_Done, a_TimedOut;
  logic [31:0]   a_CycleCount;
  logic [DW-1:0] a_HaltPC, a_Signature;
  logic          c_CoreRst, c_Running, c_Done, c_TimedOut;
  logic [31:0]   c_CycleCount;
  logic [DW-1:0] c_HaltPC, c_Signature;

  pipeline_run_monitor #(.TIMEOUT(16)) dut_a (
    .Clk(Clk), .Rst(Rst), .Restart(Restart), .PCValue(PCValue), .Probes(Probes),
    .CoreRst(a_CoreRst), .Running(a_Running), .Done(a_Done), .TimedOut(a_TimedOut),
    .CycleCount(a_CycleCount), .HaltPC(a_HaltPC), .Signature(a_Signature)
  );

  pipeline_run_monitor #(.TIMEOUT(8)) dut_c (
    .Clk(Clk), .Rst(Rst), .Restart(Restart), .PCValue(PCValue), .Probes(Probes),
    .CoreRst(c_CoreRst), .Running(c_Running), .Done(c_Done), .TimedOut(c_TimedOut),
    .CycleCount(c_CycleCount), .HaltPC(c_HaltPC), .Signature(c_Signature)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_c_q[$];

`ifdef RUN_MONITOR_SIG_EN
  localparam logic [DW-1:0] SIG1 = 32'h7;
  localparam logic [DW-1:0] SIG2 = 32'h9;
  localparam logic [DW-1:0] SIG3 = 32'h15;
`else
  localparam logic [DW-1:0] SIG1 = 32'h0;
  localparam logic [DW-1:0] SIG2 = 32'h0;
  localparam logic [DW-1:0] SIG3 = 32'h0;
`endif

  // Signature after n RUN edges from 0 with probes 1,2,4 (xor = 7).
  function automatic logic [DW-1:0] sig_after(input int n);
    logic [DW-1:0] s;
    s = '0;
`ifdef RUN_MONITOR_SIG_EN
    for (int i = 0; i < n; i++) s = {s[DW-2:0], s[DW-1]} ^ 32'h7;
`endif
    return s;
  endfunction

  function automatic logic [EW-1:0] pack(input logic t, input logic [31:0] cnt,
                                         input logic [DW-1:0] pc, input logic [DW-1:0] sig);
    return {t, cnt, pc, sig};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  logic          a_done_prev = 1'b0;
  logic          c_done_prev = 1'b0;
  logic [EW-1:0] mon_a_exp, mon_c_exp;

  always @(negedge Clk) begin
    if (a_Done && !a_done_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_a: completion with no expected entry");
      end else begin
        mon_a_exp = exp_q.pop_front();
        if ({a_TimedOut, a_CycleCount, a_HaltPC, a_Signature} !== mon_a_exp) begin
          errors++;
          $display("FAIL done_a: got timed=%0d cnt=%0d pc=0x%0h sig=0x%0h expected timed=%0d cnt=%0d pc=0x%0h sig=0x%0h",
                   a_TimedOut, a_CycleCount, a_HaltPC, a_Signature,
                   mon_a_exp[EW-1], mon_a_exp[3*DW-1:2*DW], mon_a_exp[2*DW-1:DW], mon_a_exp[DW-1:0]);
        end
      end
    end
    a_done_prev <= a_Done;
  end

  always @(negedge Clk) begin
    if (c_Done && !c_done_prev) begin
      checks++;
      if (exp_c_q.size() == 0) begin
        errors++;
        $display("FAIL done_c: completion with no expected entry");
      end else begin
        mon_c_exp = exp_c_q.pop_front();
        if ({c_TimedOut, c_CycleCount, c_HaltPC, c_Signature} !== mon_c_exp) begin
          errors++;
          $display("FAIL done_c: got timed=%0d cnt=%0d pc=0x%0h sig=0x%0h expected timed=%0d cnt=%0d pc=0x%0h sig=0x%0h",
                   c_TimedOut, c_CycleCount, c_HaltPC, c_Signature,
                   mon_c_exp[EW-1], mon_c_exp[3*DW-1:2*DW], mon_c_exp[2*DW-1:DW], mon_c_exp[DW-1:0]);
        end
      end
    end
    c_done_prev <= c_Done;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [DW-1:0] pc);
    PCValue = pc;
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_restart();
    Restart = 1'b1;
    step(0);
    Restart = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_corerst"},  a_CoreRst,    1);
    check({tag, "_running"},  a_Running,    0);
    check({tag, "_done"},     a_Done,       0);
    check({tag, "_timedout"}, a_TimedOut,   0);
    check({tag, "_cycles"},   a_CycleCount, 0);
    check({tag, "_haltpc"},   a_HaltPC,     0);
    check({tag, "_sig"},      a_Signature,  0);
    check({tag, "_done_c"},   c_Done,       0);
  endtask

  // Expects CoreRst high for exactly four more edges, then RUN with count 0.
  task automatic hold_seq(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_hold_corerst"}, a_CoreRst, 1);
      check({tag, "_hold_running"}, a_Running, 0);
      step(0);
    end
    check({tag, "_rel_corerst"}, a_CoreRst,    0);
    check({tag, "_rel_running"}, a_Running,    1);
    check({tag, "_rel_cycles"},  a_CycleCount, 0);
    check({tag, "_rel_sig"},     a_Signature,  0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Rst     = 1'b0;
    Restart = 1'b0;
    PCValue = '0;
    Probes  = {32'h4, 32'h2, 32'h1};

    // Reset sequence
    repeat (3) @(posedge Clk);
    #1;
    check_reset_vals("por");
    Rst = 1'b1;
    hold_seq("por");

    // Halt after 0,4,8 then eight samples of 12; signature on first edges
    exp_q.push_back(pack(1'b0, 32'd11, 32'd12, sig_after(11)));
    exp_c_q.push_back(pack(1'b1, 32'd8, 32'd12, sig_after(8)));
    step(0);
    check("sig_1", a_Signature, SIG1);
    check("cycles_1", a_CycleCount, 1);
    step(4);
    check("sig_2", a_Signature, SIG2);
    step(8);
    check("sig_3", a_Signature, SIG3);
    for (int i = 0; i < 7; i++) step(12);
    check("halt_not_early", a_Done, 0);
    check("halt_running_pre", a_Running, 1);
    step(12);
    check("halt_done", a_Done, 1);
    check("halt_running", a_Running, 0);
    check("halt_timedout", a_TimedOut, 0);
    check("halt_pc", a_HaltPC, 12);
    check("halt_cycles", a_CycleCount, 11);
    step(16);
    step(20);
    check("halt_frozen_cycles", a_CycleCount, 11);
    check("halt_frozen_pc", a_HaltPC, 12);
    check("halt_frozen_sig", a_Signature, sig_after(11));
    check("halt_corerst", a_CoreRst, 0);
    check("halt_sticky", a_Done, 1);

    // Restart from HALTED, then watchdog timeout with PC stepping by 4
    pulse_restart();
    check_reset_vals("restart_halted");
    hold_seq("rs1");
    exp_q.push_back(pack(1'b1, 32'd16, 32'h13C, sig_after(16)));
    exp_c_q.push_back(pack(1'b1, 32'd8, 32'h11C, sig_after(8)));
    for (int i = 0; i < 15; i++) step(32'h100 + 32'(4 * i));
    check("to_not_early", a_Done, 0);
    step(32'h13C);
    check("to_timedout", a_TimedOut, 1);
    check("to_done", a_Done, 1);
    check("to_running", a_Running, 0);
    check("to_cycles", a_CycleCount, 16);
    check("to_haltpc", a_HaltPC, 32'h13C);
    step(32'h500);
    check("to_frozen_cycles", a_CycleCount, 16);

    // Restart mid-RUN
    pulse_restart();
    check_reset_vals("restart_timeout");
    hold_seq("rs2");
    step(32'h200);
    step(32'h204);
    step(32'h208);
    check("mid_run_cycles", a_CycleCount, 3);
    pulse_restart();
    check_reset_vals("restart_run");

    // Restart in HOLD restarts the hold count
    step(0);
    step(0);
    pulse_restart();
    check_reset_vals("restart_hold");
    hold_seq("rs3");

    // Async reset mid-RUN, restart ignored while reset low
    step(32'h300);
    step(32'h304);
    Rst = 1'b0;
    #1;
    check_reset_vals("rst_run");
    pulse_restart();
    check_reset_vals("rst_restart_ign");

    // Async reset mid-HOLD
    Rst = 1'b1;
    step(0);
    step(0);
    Rst = 1'b0;
    #1;
    check_reset_vals("rst_hold");
    step(0);
    Rst = 1'b1;
    hold_seq("rs4");

    // Collision on dut_c: halt and timeout on the same edge, halt wins
    exp_q.push_back(pack(1'b0, 32'd8, 32'h40, sig_after(8)));
    exp_c_q.push_back(pack(1'b0, 32'd8, 32'h40, sig_after(8)));
    for (int i = 0; i < 7; i++) step(32'h40);
    check("coll_not_early", c_Done, 0);
    step(32'h40);
    check("coll_done", c_Done, 1);
    check("coll_timedout", c_TimedOut, 0);
    check("coll_running", c_Running, 0);
    check("coll_haltpc", c_HaltPC, 32'h40);
    check("coll_cycles", c_CycleCount, 8);

    // Every expected completion must have been observed
    step(0);
    check("pending_a", exp_q.size(), 0);
    check("pending_c", exp_c_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
